// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic scan sequencer.
package ultrasonic_pkg;

   localparam int unsigned IDX_W = 4;   // sensor index / mux select width
   localparam int unsigned CNT_W = 32;  // phase and tick counter width

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      TRIG,
      WAIT_RISE,
      MEASURE,
      PUBLISH,
      RECOVER
   } state_t;

   // All-ones code of a dist_w-bit distance (dist_w in 1..32).
   function automatic logic [31:0] timeout_code(input int unsigned dist_w);
      return 32'hFFFF_FFFF >> (32 - dist_w);
   endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchroniser for the asynchronous echo line plus rise/fall edge pulses.
module echo_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_echo,
   output logic o_level,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronise the echo and keep one cycle of history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_echo;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level  = r_sync;
   assign o_rise_c = r_sync & ~r_prev;
   assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/ultrasonic_scan_sequencer.sv
// Round-robin ultrasonic ranging sequencer with per-sensor distance table.
// Optional nearest-obstacle tracking is built when ULTRASONIC_NEAREST_EN is defined.
module ultrasonic_scan_sequencer
   import ultrasonic_pkg::*;
#(
   parameter int unsigned NUM_SENSORS    = 4,
   parameter int unsigned SETTLE_CYCLES  = 50,
   parameter int unsigned TRIG_CYCLES    = 500,
   parameter int unsigned TICK_DIV       = 2900,
   parameter int unsigned TIMEOUT_CYCLES = 1500000,
   parameter int unsigned GAP_CYCLES     = 3000000,
   parameter int unsigned DIST_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              echo_rx,
   output logic              trig_tx,
   output logic [IDX_W-1:0]  mux_sensor_select,
   output logic              dist_valid,
   output logic [IDX_W-1:0]  dist_id,
   output logic [DIST_W-1:0] dist_value,
   output logic              dist_timeout,
   output logic              scan_done,
   output logic              busy,
   input  logic [IDX_W-1:0]  rd_sel,
   output logic [DIST_W-1:0] rd_dist,
   output logic [DIST_W-1:0] nearest_dist,
   output logic [IDX_W-1:0]  nearest_id
);

   localparam logic [DIST_W-1:0] TIMEOUT_CODE = DIST_W'(timeout_code(DIST_W));
   localparam logic [DIST_W-1:0] DIST_MAX     = TIMEOUT_CODE - DIST_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_SENSORS - 1);
   localparam logic [IDX_W:0]    NUM_EXT      = (IDX_W + 1)'(NUM_SENSORS);
   localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DIV_LAST     = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  TMO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam int unsigned       TAB_N        = 1 << IDX_W;

   state_t             r_state;
   state_t             w_state_d;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_d;
   logic               w_timeout;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_div;
   logic [DIST_W-1:0]  r_dist;
   logic [DIST_W-1:0]  r_table [TAB_N];
   logic               w_level;
   logic               w_rise_c;
   logic               w_fall_c;
   logic               w_cnt_clr_c;
   logic               w_high_c;
   logic               w_scan_end_c;

   echo_sync_edge u_echo_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_echo   (echo_rx),
      .o_level  (w_level),
      .o_rise_c (w_rise_c),
      .o_fall_c (w_fall_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_d;
   end

   // Next-state, sensor index and timeout decision; dropping enable aborts to IDLE.
   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      w_timeout = 1'b0;
      if (r_state != IDLE && !enable) begin
         w_state_d = IDLE;
      end else begin
         case (r_state)
            IDLE:      if (enable) w_state_d = SELECT;
            SELECT:    if (r_cnt == SETTLE_LAST) w_state_d = TRIG;
            TRIG:      if (r_cnt == TRIG_LAST) w_state_d = WAIT_RISE;
            WAIT_RISE: begin
               if (w_rise_c) begin
                  w_state_d = MEASURE;
               end else if (r_cnt >= TMO_LAST) begin
                  w_state_d = PUBLISH;
                  w_timeout = 1'b1;
               end
            end
            MEASURE: begin
               if (w_fall_c) begin
                  w_state_d = PUBLISH;
               end else if (r_cnt >= TMO_LAST) begin
                  w_state_d = PUBLISH;
                  w_timeout = 1'b1;
               end
            end
            PUBLISH:   w_state_d = RECOVER;
            RECOVER:   if (r_cnt == GAP_LAST) w_state_d = SELECT;
            default:   w_state_d = IDLE;
         endcase
      end
      if (w_state_d == IDLE) begin
         w_idx_d = '0;
      end else if (r_state == RECOVER && w_state_d == SELECT) begin
         w_idx_d = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Phase counter restarts on each state change; the timeout span keeps counting into MEASURE.
   assign w_cnt_clr_c  = (w_state_d != r_state) && !(r_state == WAIT_RISE && w_state_d == MEASURE);
   assign w_high_c     = (r_state == WAIT_RISE && w_rise_c) || (r_state == MEASURE && w_level);
   assign w_scan_end_c = (r_state == PUBLISH) && (w_state_d == RECOVER) && (r_idx == LAST_IDX);

   // Phase counter and sensor index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         r_idx <= w_idx_d;
         if (w_cnt_clr_c)         r_cnt <= '0;
         else if (r_state != IDLE) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Echo-high cycles are divided down to distance ticks; the tick count saturates below the timeout code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_dist <= '0;
      end else if (r_state == TRIG) begin
         r_div  <= '0;
         r_dist <= '0;
      end else if (w_high_c) begin
         if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_dist != DIST_MAX) r_dist <= r_dist + DIST_W'(1);
         end else begin
            r_div <= r_div + CNT_W'(1);
         end
      end
   end

   // Registered outputs, aligned with the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_tx           <= 1'b0;
         busy              <= 1'b0;
         mux_sensor_select <= '0;
         dist_valid        <= 1'b0;
         dist_id           <= '0;
         dist_value        <= TIMEOUT_CODE;
         dist_timeout      <= 1'b0;
         scan_done         <= 1'b0;
      end else begin
         trig_tx    <= (w_state_d == TRIG);
         busy       <= (w_state_d != IDLE);
         dist_valid <= (w_state_d == PUBLISH);
         scan_done  <= w_scan_end_c;
         if (w_state_d == SELECT) mux_sensor_select <= w_idx_d;
         if (w_state_d == PUBLISH) begin
            dist_id      <= r_idx;
            dist_value   <= w_timeout ? TIMEOUT_CODE : r_dist;
            dist_timeout <= w_timeout;
         end
      end
   end

   // Distance table, written during the publish cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_table <= '{default: TIMEOUT_CODE};
      else if (r_state == PUBLISH) r_table[r_idx] <= dist_value;
   end

   assign rd_dist = ({1'b0, rd_sel} < NUM_EXT) ? r_table[rd_sel] : TIMEOUT_CODE;

`ifdef ULTRASONIC_NEAREST_EN
   logic [DIST_W-1:0] r_min_dist;
   logic [IDX_W-1:0]  r_min_id;
   logic              w_take_c;
   logic [DIST_W-1:0] w_min_dist_c;
   logic [IDX_W-1:0]  w_min_id_c;

   assign w_take_c     = (r_state == PUBLISH) && !dist_timeout && (dist_value < r_min_dist);
   assign w_min_dist_c = w_take_c ? dist_value : r_min_dist;
   assign w_min_id_c   = w_take_c ? r_idx : r_min_id;

   // Running minimum over the scan; strict compare keeps the lower index on ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_min_dist   <= TIMEOUT_CODE;
         r_min_id     <= '0;
         nearest_dist <= TIMEOUT_CODE;
         nearest_id   <= '0;
      end else if (w_scan_end_c) begin
         nearest_dist <= w_min_dist_c;
         nearest_id   <= w_min_id_c;
         r_min_dist   <= TIMEOUT_CODE;
         r_min_id     <= '0;
      end else if (r_state == IDLE) begin
         r_min_dist   <= TIMEOUT_CODE;
         r_min_id     <= '0;
      end else if (w_take_c) begin
         r_min_dist   <= w_min_dist_c;
         r_min_id     <= w_min_id_c;
      end
   end
`else
   assign nearest_dist = TIMEOUT_CODE;
   assign nearest_id   = '0;
`endif

endmodule

// File: doc/ultrasonic_scan_sequencer.md
Name: ultrasonic_scan_sequencer

Overview:
Sequences the shared ultrasonic ranging path (one trigger line, one echo line, external 16-way sensor mux) across NUM_SENSORS sensors in round-robin order. For each sensor it selects the mux channel, waits for settling, issues a trigger pulse, and measures echo width in distance ticks (~1 cm each), with timeout. It publishes one result per sensor and holds a per-sensor distance table for the robot navigation logic. It sits between the robot top-level control and the trig_tx, echo_rx and mux_sensor_select pins.

Parameters:
NUM_SENSORS, 4, sensors scanned (1..16); indices 0..NUM_SENSORS-1
SETTLE_CYCLES, 50, mux settle time before trigger
TRIG_CYCLES, 500, trigger high width (10 us at 50 MHz)
TICK_DIV, 2900, clk cycles of echo-high per distance tick (58 us/cm at 50 MHz)
TIMEOUT_CYCLES, 1500000, max cycles from trigger fall to echo fall (30 ms)
GAP_CYCLES, 3000000, dead time after each sensor for echo decay
DIST_W, 16, distance width; all-ones is reserved as TIMEOUT_CODE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable (robot_enable)
echo_rx  in  1  raw echo from sensor mux, asynchronous
trig_tx  out  1  trigger pulse to all sensors
mux_sensor_select  out  4  selected sensor channel
dist_valid  out  1  one-cycle pulse: new result
dist_id  out  4  sensor index of the result
dist_value  out  DIST_W  distance in ticks, or TIMEOUT_CODE
dist_timeout  out  1  qualifies dist_valid: no echo, or echo too long
scan_done  out  1  one-cycle pulse after the last sensor's result
busy  out  1  FSM not in IDLE
rd_sel  in  4  table read index
rd_dist  out  DIST_W  table entry rd_sel (combinational read); TIMEOUT_CODE if rd_sel >= NUM_SENSORS
nearest_dist  out  DIST_W  see Optional Feature
nearest_id  out  4  see Optional Feature

Behaviour:
- Reset behaviour:
  - All outputs are 0, except dist_value, nearest_dist and every table entry, which are TIMEOUT_CODE.
  - FSM is in IDLE and the sensor index is 0.
- Echo input: echo_rx passes through a 2-FF synchroniser, then a rise/fall edge detector. Only synchronised edges are used.
- FSM states and transitions:
  - IDLE: leaves for SELECT while enable=1.
  - SELECT: mux_sensor_select=idx; wait SETTLE_CYCLES.
  - TRIG: trig_tx=1 for exactly TRIG_CYCLES cycles.
  - WAIT_RISE: a rising edge goes to MEASURE. Echo already high on entry is not accepted; a genuine rise is required.
  - MEASURE: count cycles; the distance counter increments once per TICK_DIV echo-high cycles. The falling edge goes to PUBLISH.
  - PUBLISH: one cycle. dist_valid=1, dist_id=idx, dist_value=count, and table[idx] is written.
  - RECOVER: wait GAP_CYCLES. If idx=NUM_SENSORS-1, pulse scan_done, set idx to 0 and go to SELECT if enable=1, else IDLE. Otherwise increment idx and go to SELECT.
- Timing:
  - dist_value = floor(high_cycles/TICK_DIV).
  - dist_valid rises on the 3rd clk edge after echo_rx falls (2 synchroniser edges + 1).
  - scan_done is asserted one cycle after the last dist_valid.
- Timeout: one counter runs from trigger fall through WAIT_RISE and MEASURE. On reaching TIMEOUT_CYCLES, go to PUBLISH with dist_value=TIMEOUT_CODE and dist_timeout=1.
- Saturation: the distance counter saturates at TIMEOUT_CODE-1 and never wraps.
- mux_sensor_select: held constant from SELECT through RECOVER, and only changes in SELECT.
- enable deasserted mid-sensor: abort in the next cycle to IDLE. trig_tx=0, no publish, table unchanged. idx resets to 0 and the next scan starts at sensor 0.
- NUM_SENSORS=1: every result is followed by scan_done.
- Table write and rd_sel read in the same cycle: rd_dist returns the old value, and the new value from the next cycle.

Optional Feature:
ULTRASONIC_NEAREST_EN.
- Defined:
  - A running minimum of non-timeout results is kept within the scan; ties keep the lower index.
  - nearest_dist and nearest_id are updated in the same cycle as scan_done.
  - If every result in the scan timed out, nearest_dist=TIMEOUT_CODE and nearest_id=0.
  - The running minimum resets at scan start.
- Undefined: the ports remain; nearest_dist is tied to TIMEOUT_CODE and nearest_id to 0, with no comparator logic.

Decomposition:
- Package ultrasonic_pkg holds:
  - the state enum (IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, PUBLISH, RECOVER);
  - the TIMEOUT_CODE function of DIST_W;
  - the sensor index width constant (4).
- Sub-module echo_sync_edge: 2-FF synchroniser, rise/fall pulses, reset to 0.

Test Plan:
Bench parameters: NUM_SENSORS=4, SETTLE=4, TRIG=10, TICK_DIV=4, TIMEOUT=400, GAP=8.
1. enable=1, echo high 40 cycles starting 20 cycles after trig falls -> trig_tx high exactly 10 cycles; dist_valid with dist_id=0, dist_value=10, dist_timeout=0, 3 cycles after echo falls; rd_sel=0 gives 10.
2. No echo for sensor 1 -> after 400 cycles, dist_valid with dist_id=1, dist_value=16'hFFFF, dist_timeout=1.
3. Full scan with echo widths 40/12/400+/20 on sensors 0-3 -> dist_id 0,1,2,3 in order; values 10, 3, FFFF, 5; scan_done one cycle after id 3; mux_sensor_select wraps 3 to 0.
4. echo_rx held high from before the trigger -> no MEASURE, and timeout is reported; then echo low, then 16-cycle pulse -> next sensor gets 4.
5. enable dropped during MEASURE of sensor 2 -> trig_tx=0, busy=0 next cycle, no dist_valid, table[2] unchanged; re-enable -> first result has dist_id=0.
6. With ULTRASONIC_NEAREST_EN, scan 10/3/FFFF/3 -> at scan_done nearest_dist=3, nearest_id=1. Without it, nearest_dist=16'hFFFF and nearest_id=0.
